mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned MEM_LAT_MAX_DEF  = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  // Command held toward memory for the whole transaction
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Bits needed to hold 0..max_val (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
// slave is the arbiter's view; master is the requesters plus memory.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;

  logic              timeout_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output if_rdata, if_ready, d_rdata, d_ready,
    output m_req, m_we, m_addr, m_wdata, timeout_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  if_rdata, if_ready, d_rdata, d_ready,
    input  m_req, m_we, m_addr, m_wdata, timeout_err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data
// access, data first with a starvation bound, plus an ack timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned MEM_LAT_MAX  = MEM_LAT_MAX_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned STARVE_W = cnt_width(STARVE_LIMIT);
  localparam int unsigned LAT_W    = cnt_width(MEM_LAT_MAX);

  arb_state_e        state;
  mem_cmd_t          cmd;
  logic              m_req_q;
  logic              if_ready_q;
  logic              d_ready_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [STARVE_W-1:0] starve_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              timeout_err_q;

  logic                idle_ok_c;
  logic                pick_d_c;
  logic                lat_expired_c;
  logic [STARVE_W-1:0] starve_next_c;

  // Arbitrate only once both ready pulses are gone, so a requester still
  // holding its request during its own ready cycle is not served twice.
  assign idle_ok_c     = ~(if_ready_q | d_ready_q);
  assign pick_d_c      = bus.d_req && (!bus.if_req || (starve_cnt < STARVE_W'(STARVE_LIMIT)));
  assign lat_expired_c = (MEM_LAT_MAX != 0) && (lat_cnt == LAT_W'(MEM_LAT_MAX - 1));
  assign starve_next_c = (starve_cnt == STARVE_W'(STARVE_LIMIT)) ? starve_cnt
                                                                  : starve_cnt + STARVE_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cmd           <= '0;
      m_req_q       <= 1'b0;
      if_ready_q    <= 1'b0;
      d_ready_q     <= 1'b0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      starve_cnt    <= '0;
      lat_cnt       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_ok_c) begin
            if (pick_d_c) begin
              state      <= GRANT_D;
              cmd        <= '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata};
              m_req_q    <= 1'b1;
              lat_cnt    <= '0;
              starve_cnt <= bus.if_req ? starve_next_c : '0;
            end else if (bus.if_req) begin
              state      <= GRANT_I;
              cmd        <= '{we: 1'b0, addr: bus.if_addr, wdata: '0};
              m_req_q    <= 1'b1;
              lat_cnt    <= '0;
              starve_cnt <= '0;
            end
          end
        end
        GRANT_I, GRANT_D: begin
          if (bus.m_ack || lat_expired_c) begin
            state   <= IDLE;
            m_req_q <= 1'b0;
            lat_cnt <= '0;
            if (!bus.m_ack) timeout_err_q <= 1'b1;
            if (state == GRANT_I) begin
              if_ready_q <= 1'b1;
              if_rdata_q <= bus.m_ack ? bus.m_rdata : '0;
            end else begin
              d_ready_q <= 1'b1;
              // Stores keep the last load value; a timeout returns zero
              if (!bus.m_ack)   d_rdata_q <= '0;
              else if (!cmd.we) d_rdata_q <= bus.m_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          m_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_req       = m_req_q;
  assign bus.m_we        = cmd.we;
  assign bus.m_addr      = cmd.addr;
  assign bus.m_wdata     = cmd.wdata;
  assign bus.if_ready    = if_ready_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.d_ready     = d_ready_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
